lcd_rd_ctrl: RTL
================

Name: lcd_rd_ctrl

Overview:
- Read-side bus controller for the HD44780-compatible character LCD, the counterpart to the existing write-only LCD driver.
- Performs single read cycles (RW=1) of two kinds: busy-flag/address read (RS=0) and DDRAM/CGRAM data read (RS=1).
- Also supports a busy-poll mode: it re-reads the busy flag until BF=0 or a poll limit is reached.
- Lets the write path replace fixed delays with busy-flag polling; a request/valid handshake connects it to the upstream sequencer.

Parameters:
- SETUP_CYC, 4: cycles RS/RW are stable with E low before E rises (tAS); must be >=1.
- E_HIGH_CYC, 25: cycles E is held high (PW_EH); data is sampled on the last of them; must be >=1.
- HOLD_CYC, 25: cycles E is low after the fall before the cycle ends (tH plus recovery); must be >=1.
- MAX_POLLS, 1000: maximum busy-flag reads in poll mode; must be >=1 and <=65535.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, 1: start request; sampled only in IDLE.
- req_rs, input, 1: register select for the read, 0 = busy/address, 1 = data; ignored when req_poll=1.
- req_poll, input, 1: 1 = busy-poll transaction (forces RS=0).
- busy, output, 1: high in every state except IDLE.
- rd_data, output, 8: byte captured from the LCD; held until the next capture.
- rd_valid, output, 1: one-cycle pulse when a transaction completes.
- timeout, output, 1: valid with rd_valid; 1 = poll limit reached with BF still 1.
- lcd_data_in, input, 8: LCD DB7..DB0 as seen at the pins.
- lcd_e, output, 1: LCD enable strobe.
- lcd_rs, output, 1: LCD register select.
- lcd_rw, output, 1: LCD read/write; 1 = read.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state=IDLE; lcd_e=0, lcd_rs=0, lcd_rw=0.
  - rd_data=8'h00, rd_valid=0, timeout=0, busy=0; all counters cleared.
  - Released bus returns to write direction (RW=0) with E low; no partial strobe is completed.
- All outputs are registered.
- FSM states: IDLE, SETUP, E_HIGH, HOLD, DONE.
- IDLE: lcd_e=0, lcd_rw=0. On req=1:
  - lcd_rs <= (req_poll ? 0 : req_rs); lcd_rw <= 1; poll_cnt <= 0; go to SETUP.
  - busy rises at this edge.
- SETUP: E low for SETUP_CYC cycles, then lcd_e <= 1 and go to E_HIGH.
- E_HIGH: E high for E_HIGH_CYC cycles. At the exit edge: rd_data <= lcd_data_in, lcd_e <= 0, go to HOLD.
- HOLD: E low for HOLD_CYC cycles. At the exit edge:
  - Non-poll: go to DONE, timeout <= 0.
  - Poll with rd_data[7]=0: go to DONE, timeout <= 0.
  - Poll with rd_data[7]=1 and poll_cnt = MAX_POLLS-1: go to DONE, timeout <= 1.
  - Poll otherwise: poll_cnt <= poll_cnt+1, go to SETUP (RS and RW held, E stays low).
- DONE: exactly one cycle.
  - rd_valid=1, busy=1; lcd_rw <= 0 and lcd_rs <= 0 at exit; go to IDLE.
  - rd_data and timeout hold their values afterwards.
- Latency: the accepting edge is edge 0. For a single read, rd_valid is first high after edge SETUP_CYC+E_HIGH_CYC+HOLD_CYC+1 (55 with defaults). A poll of n reads takes n*(S+E+H)+1.
- Phase counter: 16 bits, reloaded at every state entry, no wrap. poll_cnt: 16 bits.
- req while busy=1 (including the DONE cycle) is ignored and not queued. req held high re-triggers in the first IDLE cycle.
- lcd_rw never changes while lcd_e=1. lcd_rs never changes between leaving IDLE and entering DONE.
- The upstream arbiter guarantees the write driver does not drive the bus while busy=1; this block has no bus-drive output.

Test Plan:
- Single data read: req=1, req_rs=1, req_poll=0, lcd_data_in=8'h41 -> rs=1 and rw=1 after edge 0; E high for exactly 25 cycles; rd_valid pulse after edge 55; rd_data=8'h41; timeout=0; rw=0 afterwards.
- Busy poll clears: req_poll=1, lcd_data_in=8'h85 for the first two strobes, then 8'h05 -> exactly 3 E pulses; rs=0 throughout; rd_data=8'h05; timeout=0; rd_valid after edge 3*54+1=163.
- Poll timeout with MAX_POLLS=4: lcd_data_in fixed at 8'h80 -> exactly 4 E pulses; rd_valid with timeout=1, rd_data=8'h80.
- Reset mid-strobe: assert rst_n=0 in the 10th E_HIGH cycle -> lcd_e, lcd_rw, busy and rd_valid go low immediately (before the next edge); after release, state is IDLE and no rd_valid occurs.
- Request while busy: pulse req during SETUP and again during DONE -> neither starts a transaction; exactly one rd_valid.
- Held req: keep req=1 across completion -> a second transaction starts in the IDLE cycle after DONE; two rd_valid pulses 56 cycles apart.

Source files
------------

// File: rtl/lcd_rd_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_rd_ctrl
// Read-side bus controller for an HD44780-compatible character LCD.
// Runs single read cycles (busy-flag/address with RS=0, or DDRAM/CGRAM data
// with RS=1). In busy-poll mode it re-reads the busy flag until BF=0 or
// until MAX_POLLS reads have been made.
//
// Ports
//   clk, rst_n   : system clock, asynchronous active-low reset
//   req          : start request, sampled only while idle
//   req_rs       : register select for a single read (0 = busy/addr, 1 = data)
//   req_poll     : 1 = busy-poll transaction (RS forced to 0)
//   busy         : high whenever the controller is not idle
//   rd_data      : last byte captured from the LCD, held until the next capture
//   rd_valid     : one-cycle completion pulse
//   timeout      : qualifies rd_valid; 1 = poll limit reached with BF still 1
//   lcd_data_in  : DB7..DB0 as seen at the pins
//   lcd_e/rs/rw  : LCD strobe, register select, read/write (1 = read)
//
// Timing: edge 0 accepts the request. Each read is SETUP_CYC cycles with E
// low, E_HIGH_CYC cycles with E high (data captured on the falling edge),
// then HOLD_CYC cycles with E low. The one-cycle DONE state follows and
// rd_valid is registered out of it, so the pulse is visible in the cycle
// after DONE: edge n*(S+E+H)+1 for a transaction of n reads.
// ---------------------------------------------------------------------------
module lcd_rd_ctrl #(
  parameter int unsigned SETUP_CYC  = 4,
  parameter int unsigned E_HIGH_CYC = 25,
  parameter int unsigned HOLD_CYC   = 25,
  parameter int unsigned MAX_POLLS  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       busy,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       timeout,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HIGH,
    HOLD,
    DONE
  } state_e;

  // Phase counter is loaded with (length - 1) on entry; a phase ends in the
  // cycle where it reads zero, giving exactly <length> cycles per phase.
  localparam logic [15:0] SETUP_LD  = 16'(SETUP_CYC - 1);
  localparam logic [15:0] E_HIGH_LD = 16'(E_HIGH_CYC - 1);
  localparam logic [15:0] HOLD_LD   = 16'(HOLD_CYC - 1);
  localparam logic [15:0] POLL_LAST = 16'(MAX_POLLS - 1);

  state_e      state_q,    state_d;
  logic [15:0] phase_q,    phase_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        poll_q,     poll_d;
  logic        lcd_e_q,    lcd_e_d;
  logic        lcd_rs_q,   lcd_rs_d;
  logic        lcd_rw_q,   lcd_rw_d;
  logic [7:0]  rd_data_q,  rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        timeout_q,  timeout_d;
  logic        busy_q,     busy_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    phase_d    = (phase_q == 16'd0) ? 16'd0 : phase_q - 16'd1;
    poll_cnt_d = poll_cnt_q;
    poll_d     = poll_q;
    lcd_e_d    = lcd_e_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_rw_d   = lcd_rw_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    timeout_d  = timeout_q;

    case (state_q)
      IDLE: begin
        lcd_e_d  = 1'b0;
        lcd_rw_d = 1'b0;
        if (req) begin
          lcd_rs_d   = req_poll ? 1'b0 : req_rs;
          lcd_rw_d   = 1'b1;
          poll_cnt_d = 16'd0;
          poll_d     = req_poll;
          phase_d    = SETUP_LD;
          state_d    = SETUP;
        end
      end

      SETUP: begin
        if (phase_q == 16'd0) begin
          lcd_e_d = 1'b1;
          phase_d = E_HIGH_LD;
          state_d = E_HIGH;
        end
      end

      E_HIGH: begin
        if (phase_q == 16'd0) begin
          rd_data_d = lcd_data_in;
          lcd_e_d   = 1'b0;
          phase_d   = HOLD_LD;
          state_d   = HOLD;
        end
      end

      HOLD: begin
        if (phase_q == 16'd0) begin
          // rd_data_q[7] is the busy flag captured on this read's strobe.
          if (!poll_q || !rd_data_q[7]) begin
            timeout_d = 1'b0;
            state_d   = DONE;
          end else if (poll_cnt_q == POLL_LAST) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end else begin
            // Another poll: RS/RW stay put, E stays low through SETUP.
            poll_cnt_d = poll_cnt_q + 16'd1;
            phase_d    = SETUP_LD;
            state_d    = SETUP;
          end
        end
      end

      DONE: begin
        rd_valid_d = 1'b1;
        lcd_rw_d   = 1'b0;
        lcd_rs_d   = 1'b0;
        phase_d    = 16'd0;
        state_d    = IDLE;
      end

      default: begin
        lcd_e_d  = 1'b0;
        lcd_rw_d = 1'b0;
        lcd_rs_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= 16'd0;
      poll_cnt_q <= 16'd0;
      poll_q     <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_rw_q   <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      poll_cnt_q <= poll_cnt_d;
      poll_q     <= poll_d;
      lcd_e_q    <= lcd_e_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_rw_q   <= lcd_rw_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign timeout  = timeout_q;
  assign lcd_e    = lcd_e_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = lcd_rw_q;

endmodule
